// File: rtl/dram_pkg.sv
// dram_pkg: shared types and defaults for the DRAM responder slice.
//   dram_state_t         responder FSM states
//   DRAM_*               default widths, depth and access latencies
//   DRAM_ERR_DATA        all-ones fill returned for out-of-range reads
//   dram_idx_w()         storage index width for a given depth
`ifndef MEMORY_SIZE_ENC
`define MEMORY_SIZE_ENC 15
`endif
`ifndef MEMORY_WIDTH
`define MEMORY_WIDTH 32
`endif

package dram_pkg;

  localparam int unsigned DRAM_ADDR_W        = `MEMORY_SIZE_ENC + 1;
  localparam int unsigned DRAM_DATA_W        = `MEMORY_WIDTH;
  localparam int unsigned DRAM_DEPTH         = 256;
  localparam int unsigned DRAM_READ_LATENCY  = 4;
  localparam int unsigned DRAM_WRITE_LATENCY = 2;

  // Wide enough for any practical bus; users slice [DATA_W-1:0].
  localparam int unsigned DRAM_MAX_DATA_W = 1024;
  localparam logic [DRAM_MAX_DATA_W-1:0] DRAM_ERR_DATA = '1;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_DRIVE,
    WR_WAIT,
    RELEASE
  } dram_state_t;

  function automatic int unsigned dram_idx_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dram_storage_array.sv
// dram_storage_array: DEPTH x DATA_W word storage, no reset.
//   clk    write clock
//   we     write enable (synchronous)
//   waddr  write word index
//   wdata  write data
//   raddr  read word index (combinational read)
//   rdata  read data
module dram_storage_array #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dram_responder.sv
// dram_responder: memory-side responder for the SubCore external memory
// interface; simulation/FPGA stand-in for the DDR3 controller.
//   clk        core clock, all state changes on its rising edge
//   rst_n      asynchronous active-low reset
//   mem_addr   word address from the initiator
//   mem_data   write data in; read data out during the one-cycle response
//   mrd, mwr   level read/write strobes, held until mem_ready
//   mem_ready  one-cycle completion pulse
//   mem_err    one-cycle error pulse (out of range, or mrd and mwr together)
module dram_responder
  import dram_pkg::*;
#(
  parameter int unsigned ADDR_W        = DRAM_ADDR_W,
  parameter int unsigned DATA_W        = DRAM_DATA_W,
  parameter int unsigned DEPTH         = DRAM_DEPTH,
  parameter int unsigned READ_LATENCY  = DRAM_READ_LATENCY,
  parameter int unsigned WRITE_LATENCY = DRAM_WRITE_LATENCY
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] mem_addr,
  inout  wire  [DATA_W-1:0] mem_data,
  input  logic              mrd,
  input  logic              mwr,
  output logic              mem_ready,
  output logic              mem_err
);

  localparam int unsigned IDX_W   = dram_idx_w(DEPTH);
  localparam int unsigned MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  localparam logic [CNT_W-1:0]  RD_LOAD   = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0]  WR_LOAD   = CNT_W'(WRITE_LATENCY - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  dram_state_t       state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] store_rdata;
  logic              drive;
  logic              in_range;
  logic              wr_commit;
  logic [IDX_W-1:0]  idx;

  // Range check on the full latched address; indexing on its low bits.
  assign in_range  = ({1'b0, addr_q} < DEPTH_EXT);
  assign idx       = addr_q[IDX_W-1:0];
  assign wr_commit = (state == WR_WAIT) && (cnt == '0) && in_range;

  dram_storage_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_storage (
    .clk   (clk),
    .we    (wr_commit),
    .waddr (idx),
    .wdata (wdata_q),
    .raddr (idx),
    .rdata (store_rdata)
  );

  assign mem_data = drive ? rdata_q : 'z;

  // Latency is counted from the accepting edge to the edge that raises
  // mem_ready, so the response flags are registered on the exit from the
  // wait states; READ_LATENCY=1 therefore spends its one cycle in RD_WAIT
  // with the counter already at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      drive     <= 1'b0;
      mem_ready <= 1'b0;
      mem_err   <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      mem_err   <= 1'b0;
      drive     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (mrd && mwr) begin
            mem_err <= 1'b1;
            state   <= RELEASE;
          end else if (mrd) begin
            addr_q <= mem_addr;
            cnt    <= RD_LOAD;
            state  <= RD_WAIT;
          end else if (mwr) begin
            addr_q  <= mem_addr;
            wdata_q <= mem_data;
            cnt     <= WR_LOAD;
            state   <= WR_WAIT;
          end
        end
        RD_WAIT: begin
          if (cnt == '0) begin
            state     <= RD_DRIVE;
            mem_ready <= 1'b1;
            mem_err   <= !in_range;
            drive     <= 1'b1;
            rdata_q   <= in_range ? store_rdata : DRAM_ERR_DATA[DATA_W-1:0];
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RD_DRIVE: begin
          state <= RELEASE;
        end
        WR_WAIT: begin
          if (cnt == '0) begin
            mem_ready <= 1'b1;
            mem_err   <= !in_range;
            state     <= RELEASE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RELEASE: begin
          if (!mrd && !mwr) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
